// File: rtl/debugger_bus_master_arb.sv
// debugger_bus_master_arb: round-robin arbiter for two requesters sharing one
// Z80-style cartridge bus master (T1..T3 cycles, WAIT_n stretching, timeout).
module debugger_bus_master_arb #(
    parameter int DIV      = 30,
    parameter int WAIT_MAX = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  REQ_VALID,
    output logic [1:0]  REQ_READY,
    input  logic [1:0]  REQ_WR,
    input  logic [1:0]  REQ_IO,
    input  logic [31:0] REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    output logic [1:0]  RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_TIMEOUT,
    output logic        BUS_CLK,
    output logic [15:0] BUS_ADDR,
    output logic [7:0]  BUS_DOUT,
    input  logic [7:0]  BUS_DIN,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    input  logic        WAIT_n
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] RISE_CNT = DW'(DIV - 1);
    localparam logic [DW-1:0] FALL_CNT = DW'(DIV / 2 - 1);
    localparam int WCW = 9;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(WAIT_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_T1_0, S_T1_1, S_T2_0, S_T2_1,
        S_TW_0, S_TW_1, S_T3_0, S_T3_1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic             bus_clk_q, bus_clk_d;
    logic             last_q, last_d;
    logic             own_q, own_d;
    logic             wr_q, wr_d;
    logic             io_q, io_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]       rd_byte_q, rd_byte_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       req_ready_q, req_ready_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [15:0]      bus_addr_q, bus_addr_d;
    logic [7:0]       bus_dout_q, bus_dout_d;
    logic             merq_n_q, merq_n_d;
    logic             iorq_n_q, iorq_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;

    logic             rise, fall, tick;
    logic             grant_sel;
    logic             strobe_win, cycle_win, write_win;

    // Next-state logic: divider, arbitration, bus FSM, response and registered bus outputs
    always_comb begin
        rise          = (div_q == RISE_CNT);
        fall          = (div_q == FALL_CNT);
        tick          = rise | fall;
        div_d         = rise ? '0 : div_q + DW'(1);
        bus_clk_d     = rise ? 1'b1 : (fall ? 1'b0 : bus_clk_q);

        state_d       = state_q;
        last_d        = last_q;
        own_d         = own_q;
        wr_d          = wr_q;
        io_d          = io_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wait_cnt_d    = wait_cnt_q;
        rd_byte_d     = rd_byte_q;
        done_d        = 1'b0;
        timeout_d     = timeout_q;
        req_ready_d   = 2'b00;
        rsp_valid_d   = 2'b00;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = 1'b0;
        grant_sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Hold off arbitration while a completion is still being reported
                if (!done_q && (REQ_VALID != 2'b00)) begin
                    grant_sel              = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
                    req_ready_d[grant_sel] = 1'b1;
                    last_d                 = grant_sel;
                    own_d                  = grant_sel;
                    wr_d                   = REQ_WR[grant_sel];
                    io_d                   = REQ_IO[grant_sel];
                    addr_d                 = grant_sel ? REQ_ADDR[31:16] : REQ_ADDR[15:0];
                    wdata_d                = grant_sel ? REQ_DATA[15:8] : REQ_DATA[7:0];
                    wait_cnt_d             = '0;
                    state_d                = S_ARMED;
                end
            end
            S_ARMED: if (rise) state_d = S_T1_0;
            S_T1_0:  if (tick) state_d = S_T1_1;
            S_T1_1:  if (tick) state_d = S_T2_0;
            S_T2_0:  if (tick) state_d = S_T2_1;
            S_T2_1, S_TW_1: begin
                if (tick) begin
                    if (state_q == S_T2_1 && io_q) begin
                        state_d = S_TW_0;
                    end else if (!WAIT_n) begin
                        if (wait_cnt_q >= WAIT_LIMIT) begin
                            state_d   = S_IDLE;
                            done_d    = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WCW'(2);
                            state_d    = S_TW_0;
                        end
                    end else begin
                        state_d = S_T3_0;
                    end
                end
            end
            S_TW_0:  if (tick) state_d = S_TW_1;
            S_T3_0: begin
                if (tick) begin
                    state_d = S_T3_1;
                    if (!wr_q) rd_byte_d = BUS_DIN;
                end
            end
            S_T3_1: begin
                if (tick) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_q) begin
            rsp_valid_d[own_q] = 1'b1;
            rsp_timeout_d      = timeout_q;
            rsp_data_d         = timeout_q ? 8'hFF : rd_byte_q;
        end

        strobe_win = (state_d == S_T1_1) || (state_d == S_T2_0) || (state_d == S_T2_1) ||
                     (state_d == S_TW_0) || (state_d == S_TW_1) || (state_d == S_T3_0);
        write_win  = strobe_win && (state_d != S_T1_1);
        cycle_win  = strobe_win || (state_d == S_T1_0) || (state_d == S_T3_1);

        merq_n_d   = !(strobe_win && !io_q);
        iorq_n_d   = !(strobe_win && io_q);
        rd_n_d     = !(strobe_win && !wr_q);
        wr_n_d     = !(write_win && wr_q);
        bus_dout_d = (cycle_win && wr_q) ? wdata_q : 8'h00;
        bus_addr_d = (state_d == S_T1_0) ? addr_q : bus_addr_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bus_clk_q     <= 1'b0;
            last_q        <= 1'b1;
            own_q         <= 1'b0;
            wr_q          <= 1'b0;
            io_q          <= 1'b0;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            wait_cnt_q    <= '0;
            rd_byte_q     <= 8'h00;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            req_ready_q   <= 2'b00;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            bus_addr_q    <= 16'h0000;
            bus_dout_q    <= 8'h00;
            merq_n_q      <= 1'b1;
            iorq_n_q      <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bus_clk_q     <= bus_clk_d;
            last_q        <= last_d;
            own_q         <= own_d;
            wr_q          <= wr_d;
            io_q          <= io_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rd_byte_q     <= rd_byte_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            bus_addr_q    <= bus_addr_d;
            bus_dout_q    <= bus_dout_d;
            merq_n_q      <= merq_n_d;
            iorq_n_q      <= iorq_n_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
        end
    end

    assign REQ_READY   = req_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign BUS_CLK     = bus_clk_q;
    assign BUS_ADDR    = bus_addr_q;
    assign BUS_DOUT    = bus_dout_q;
    assign MERQ_n      = merq_n_q;
    assign IORQ_n      = iorq_n_q;
    assign RD_n        = rd_n_q;
    assign WR_n        = wr_n_q;

endmodule
